// File: rtl/vid_fb_arbiter.sv
// Frame-buffer arbiter: display fetch > clear engine > generic writer on one single-port RAM.
// Define VID_FB_CLEAR_EN to build the clear engine; without it the writer owns every free slot.
module vid_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 17
) (
    input  logic                  pll_clk,
    input  logic                  reset_P,
    input  logic [11:0]           horz_count,
    input  logic [11:0]           vert_count,
    input  logic                  v_on,
    input  logic                  wr_valid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [4*PIX_W-1:0]    wr_data,
    output logic                  wr_ready,
    input  logic                  clr_start,
    input  logic [PIX_W-1:0]      clr_color,
    output logic                  clr_busy,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [4*PIX_W-1:0]    mem_wdata,
    input  logic [4*PIX_W-1:0]    mem_rdata,
    output logic [PIX_W-1:0]      pix_data,
    output logic                  pix_de
);

    localparam int WORD_W = 4 * PIX_W;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(H_ACTIVE * V_ACTIVE / 4 - 1);

    logic              display_slot;
    logic [ADDR_W-1:0] rd_ptr;
    logic              load_d;
    logic [WORD_W-1:0] shreg;
    logic              de_d1;
    logic              clearing;
    logic [ADDR_W-1:0] clr_ptr;
    logic [PIX_W-1:0]  fill;
    logic              unused_inputs;

    // One word feeds four pixels, so the display needs every fourth active cycle.
    assign display_slot = v_on && (horz_count[1:0] == 2'b00);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pll_clk) begin
        if (reset_P) begin
            rd_ptr <= '0;
        end else if (display_slot) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
        end else if (!v_on && vert_count >= 12'(V_ACTIVE)) begin
            rd_ptr <= '0;
        end
    end

    // RAM data arrives one cycle after the slot; load it then, otherwise shift LSB-first.
    always_ff @(posedge pll_clk) begin
        if (reset_P) begin
            load_d <= 1'b0;
            shreg  <= '0;
            de_d1  <= 1'b0;
            pix_de <= 1'b0;
        end else begin
            load_d <= display_slot;
            shreg  <= load_d ? mem_rdata : (shreg >> PIX_W);
            de_d1  <= v_on;
            pix_de <= de_d1;
        end
    end

    assign pix_data = pix_de ? shreg[PIX_W-1:0] : '0;

`ifdef VID_FB_CLEAR_EN
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state;
    logic   busy_q;

    always_ff @(posedge pll_clk) begin
        if (reset_P) begin
            state   <= IDLE;
            clr_ptr <= '0;
            fill    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        fill    <= clr_color;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_start is deliberately not looked at here: a clear never restarts.
                    if (!display_slot) begin
                        if (clr_ptr == LAST_WORD) begin
                            state   <= IDLE;
                            clr_ptr <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            clr_ptr <= clr_ptr + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign clearing      = (state == CLEAR);
    assign clr_busy      = busy_q;
    assign unused_inputs = ^horz_count[11:2];
`else
    assign clearing      = 1'b0;
    assign clr_ptr       = '0;
    assign fill          = '0;
    assign clr_busy      = 1'b0;
    assign unused_inputs = ^{horz_count[11:2], clr_start, clr_color};
`endif

    // NOTE: every output gets a default before the branches, so no path can infer a latch.
    always_comb begin
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = rd_ptr;
        mem_wdata = '0;
        if (!reset_P && !display_slot) begin
            if (clearing) begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr;
                mem_wdata = {4{fill}};
            end else begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_fb_arbiter.sv
// Scoreboard bench for vid_fb_arbiter on a reduced 16x4 raster with a behavioural RAM.
// Clear-engine checks follow VID_FB_CLEAR_EN; without it clr_start must have no effect.
module tb_vid_fb_arbiter;

    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 4;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 8;
    localparam int H_TOTAL  = 24;
    localparam int V_TOTAL  = 6;
    localparam int WORDS    = H_ACTIVE * V_ACTIVE / 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              pll_clk;
    logic              reset_P;
    logic [11:0]       horz_count;
    logic [11:0]       vert_count;
    logic              v_on;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;
    logic              clr_start;
    logic [7:0]        clr_color;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [7:0]        pix_data;
    logic              pix_de;

    vid_fb_arbiter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .PIX_W   (PIX_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .pll_clk   (pll_clk),
        .reset_P   (reset_P),
        .horz_count(horz_count),
        .vert_count(vert_count),
        .v_on      (v_on),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_de    (pix_de)
    );

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h44332211 : 32'h10203040 + 32'(i) * 32'h01010101;
    endfunction

    logic        preload;
    logic [31:0] ram [DEPTH];

    always @(posedge pll_clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int          checks = 0;
    int          errors = 0;
    int          h = 0;
    int          v = 0;
    int          exp_rd = 0;
    logic [31:0] exp_fb [DEPTH];
    logic [31:0] cur_word = '0;
    logic [7:0]  pix_q [$];
    bit          von_d1 = 1'b0;
    bit          von_d2 = 1'b0;
    bit          exp_busy = 1'b0;
    int          clr_cnt = 0;
    logic [7:0]  fill = '0;
    bit          wr_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (h=%0d v=%0d)", tag, act, exp, h, v);
        end
    endtask

    // Compares this cycle's outputs with the model, then advances the model across the edge.
    task automatic monitor();
        bit slot;
        slot    = v_on && (h % 4 == 0);
        wr_done = 1'b0;
        if (reset_P) begin
            check("rst_wr_ready", 32'(wr_ready), 0);
            check("rst_mem_we", 32'(mem_we), 0);
        end else if (slot) begin
            check("slot_we", 32'(mem_we), 0);
            check("slot_addr", 32'(mem_addr), exp_rd);
            check("slot_wr_ready", 32'(wr_ready), 0);
        end else if (exp_busy) begin
            check("clr_wr_ready", 32'(wr_ready), 0);
            check("clr_we", 32'(mem_we), 1);
            check("clr_addr", 32'(mem_addr), clr_cnt);
            check("clr_wdata", mem_wdata, {4{fill}});
        end else begin
            check("idle_wr_ready", 32'(wr_ready), 1);
            check("idle_we", 32'(mem_we), 32'(wr_valid));
            if (wr_valid) begin
                check("wr_addr", 32'(mem_addr), 32'(wr_addr));
                check("wr_wdata", mem_wdata, wr_data);
                exp_fb[wr_addr] = wr_data;
                wr_done = 1'b1;
            end
        end
        check("clr_busy", 32'(clr_busy), 32'(exp_busy));
        check("pix_de", 32'(pix_de), 32'(von_d2));
        if (von_d2) begin
            if (pix_q.size() != 0) check("pix_data", 32'(pix_data), 32'(pix_q.pop_front()));
        end else begin
            check("pix_blank", 32'(pix_data), 0);
        end

        if (reset_P) begin
            exp_rd   = 0;
            cur_word = '0;
            von_d1   = 1'b0;
            von_d2   = 1'b0;
            pix_q.delete();
            exp_busy = 1'b0;
            clr_cnt  = 0;
        end else begin
            if (slot) begin
                cur_word = exp_fb[exp_rd];
                exp_rd   = (exp_rd + 1) % DEPTH;
            end else if (!v_on && v >= V_ACTIVE) begin
                exp_rd = 0;
            end
            if (v_on) pix_q.push_back(8'(cur_word >> (8 * (h % 4))));
            von_d2 = von_d1;
            von_d1 = v_on;
`ifdef VID_FB_CLEAR_EN
            if (exp_busy) begin
                if (!slot) begin
                    exp_fb[clr_cnt] = {4{fill}};
                    if (clr_cnt == WORDS - 1) begin
                        exp_busy = 1'b0;
                        clr_cnt  = 0;
                    end else begin
                        clr_cnt++;
                    end
                end
            end else if (clr_start) begin
                exp_busy = 1'b1;
                clr_cnt  = 0;
                fill     = clr_color;
            end
`endif
        end
    endtask

    task automatic cycle();
        horz_count = 12'(h);
        vert_count = 12'(v);
        v_on       = (h < H_ACTIVE) && (v < V_ACTIVE);
        #1;
        monitor();
        @(posedge pll_clk);
        #1;
        h++;
        if (h == H_TOTAL) begin
            h = 0;
            v = (v + 1) % V_TOTAL;
        end
    endtask

    task automatic run_to(input int th, input int tv);
        int n;
        n = 0;
        while (!(h == th && v == tv) && n < 2 * H_TOTAL * V_TOTAL) begin
            cycle();
            n++;
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        do begin
            cycle();
            n++;
        end while (!wr_done && n < 64);
    endtask

    initial begin
        reset_P    = 1'b1;
        preload    = 1'b1;
        horz_count = '0;
        vert_count = '0;
        v_on       = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        clr_start  = 1'b0;
        clr_color  = '0;
        for (int i = 0; i < DEPTH; i++) exp_fb[i] = init_word(i);
        @(posedge pll_clk);
        #1;
        preload = 1'b0;

        // Reset held in vertical blanking, then a clean frame of the preloaded pattern.
        h = 0;
        v = V_ACTIVE;
        repeat (3) cycle();
        reset_P = 1'b0;
        run_to(0, 0);
        run_to(0, V_ACTIVE);

        // Writer held valid through active line 0: word 5 lands before line 1 fetches it.
        run_to(0, 0);
        for (int k = 0; k < 12; k++) begin
            if (k == 0) write_word(8'd5, 32'hCAFEF00D);
            else if (k == 11) write_word(8'd200, 32'h0BADBEEF);
            else write_word(8'(32 + k), $urandom);
        end
        wr_valid = 1'b0;
        run_to(0, V_ACTIVE);

        // Blanking: the writer gets every cycle.
        for (int k = 0; k < 4; k++) write_word(8'(50 + k), $urandom);
        wr_valid = 1'b0;
        run_to(0, 0);

        // Reset for three cycles in the middle of line 1.
        run_to(6, 1);
        reset_P = 1'b1;
        repeat (3) cycle();
        reset_P = 1'b0;
        run_to(0, V_ACTIVE);
        run_to(0, 0);

        // Clear collides with a writer transfer, then a second start request mid-clear.
        run_to(1, 0);
        wr_valid  = 1'b1;
        wr_addr   = 8'd3;
        wr_data   = 32'hDEADBEEF;
        clr_start = 1'b1;
        clr_color = 8'hA5;
        cycle();
        wr_valid  = 1'b0;
        clr_start = 1'b0;
        repeat (5) cycle();
        clr_start = 1'b1;
        clr_color = 8'h5A;
        cycle();
        clr_start = 1'b0;
        for (int n = 0; n < 200 && exp_busy; n++) cycle();
        repeat (3) cycle();

        // Reset part-way through a second clear.
        clr_start = 1'b1;
        clr_color = 8'h3C;
        cycle();
        clr_start = 1'b0;
        for (int n = 0; n < 200 && exp_busy && clr_cnt < WORDS / 2; n++) cycle();
        reset_P = 1'b1;
        cycle();
        reset_P = 1'b0;
        repeat (2) cycle();

        // One more full frame on the final contents, then sweep the RAM.
        run_to(0, 0);
        run_to(0, V_ACTIVE);
        for (int i = 0; i < DEPTH; i++) check($sformatf("ram[%0d]", i), ram[i], exp_fb[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vid_fb_arbiter.md
# vid_fb_arbiter

Frame-buffer access controller between the VGA timing generator and a single-port synchronous frame-buffer RAM. It shares the RAM among three requesters:
- the display fetch, which has absolute priority during active video and streams pixels to the DAC path;
- an optional clear engine;
- a generic writer (draw engine / host) over a valid/ready handshake.

It runs on the pixel clock and consumes the timing generator's horz_count, vert_count and v_on.

## Interface
- H_ACTIVE, 640, active pixels per line; must be a multiple of 4
- V_ACTIVE, 480, active lines per frame
- PIX_W, 8, bits per pixel; one RAM word holds 4 pixels
- ADDR_W, 17, RAM word address width; must hold H_ACTIVE*V_ACTIVE/4 - 1

Ports:
- pll_clk  in  1  pixel clock; all logic on rising edge
- reset_P  in  1  synchronous, active-high reset
- horz_count  in  12  horizontal position from timing generator
- vert_count  in  12  vertical position from timing generator
- v_on  in  1  active-video flag from timing generator
- wr_valid  in  1  writer request
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  4*PIX_W  writer word
- wr_ready  out  1  writer slot granted this cycle
- clr_start  in  1  one-cycle pulse: fill buffer with clr_color
- clr_color  in  PIX_W  fill pixel value, sampled on clr_start
- clr_busy  out  1  clear in progress
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  4*PIX_W  RAM write data
- mem_rdata  in  4*PIX_W  RAM read data, valid 1 cycle after address
- pix_data  out  PIX_W  pixel to DAC path
- pix_de  out  1  pix_data valid (v_on delayed 2 cycles)

## Operation
- **Display slot:** any cycle with v_on=1 and horz_count[1:0]=0.
  - mem_addr = rd_ptr and mem_we = 0.
  - rd_ptr increments after each display slot.
  - rd_ptr clears to 0 in any cycle with v_on=0 and vert_count >= V_ACTIVE.
- **Unpack:**
  - mem_rdata is loaded into a 4*PIX_W shift register one cycle after the display slot.
  - pix_data = shreg[PIX_W-1:0]; the register shifts right by PIX_W every cycle.
  - Pixel order within a word is LSB first.
  - pix_data = 0 whenever pix_de = 0.
- **Non-display cycles:** arbitrated by FSM state. Priority is display > clear > writer.
- **FSM states:**
  - IDLE: writer owns free slots. wr_ready = 1 in every non-display cycle. A transfer occurs when wr_valid && wr_ready, driving mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - IDLE -> CLEAR on clr_start. clr_color is latched and clr_ptr is set to 0.
  - CLEAR: clr_busy = 1 and wr_ready = 0. Each non-display cycle writes clr_color replicated 4x to clr_ptr, then clr_ptr++.
  - CLEAR -> IDLE after the write at H_ACTIVE*V_ACTIVE/4 - 1.
- clr_start is ignored while in CLEAR; the clear is not restarted.
- wr_ready is combinational from v_on, horz_count[1:0] and state. Writers must hold wr_valid, wr_addr and wr_data stable until the transfer.
- A writer address beyond the buffer size is written as given; it is the caller's responsibility.

## Timing
- **Reset:** reset_P high for one edge forces the following:
  - state = IDLE, rd_ptr = 0, clr_ptr = 0, shreg = 0;
  - pix_de = 0, pix_data = 0, clr_busy = 0;
  - wr_ready = 0 and mem_we = 0 while reset_P is high.
- **Reset mid-clear** aborts the clear; memory contents are left partial.
- **Pixel latency:** the pixel for (h, v) appears on pix_data 2 cycles after horz_count = h with v_on = 1.
- **Write latency:** RAM is written on the edge ending the granted cycle; no added latency.
- **Writer bandwidth:** during active video, at most 3 of every 4 cycles. During blanking, every cycle.
- **Clear duration:** at least H_ACTIVE*V_ACTIVE/4 cycles (76800 at defaults) plus cycles lost to display slots.
- **Simultaneous events:** when clr_start and wr_valid occur in the same IDLE cycle, the writer transfer completes in that cycle and CLEAR starts on the next cycle.

## Configuration
- VID_FB_CLEAR_EN defined: clear engine and CLEAR state are built.
- VID_FB_CLEAR_EN undefined:
  - no CLEAR state;
  - clr_start and clr_color are ignored;
  - clr_busy is tied to 0;
  - the writer owns all non-display cycles.

## Test plan
- **Reset:** hold reset_P 3 cycles mid-frame -> pix_de=0, pix_data=0, mem_we=0, wr_ready=0; rd_ptr restarts at 0.
- **Display fetch:** preload word 0 = 0x44332211 and run a frame from vert_count=0 -> mem_addr=0 at h=0; pix_data = 0x11, 0x22, 0x33, 0x44 on the cycles corresponding to h = 0..3, each 2 cycles after h.
- **Writer during active video:** hold wr_valid=1 continuously -> wr_ready=0 exactly when horz_count[1:0]=0; 3 writes per 4 cycles; written word reads back.
- **Clear:** clr_start with clr_color=0xA5 -> clr_busy=1, wr_ready=0. Afterwards all 76800 words = 0xA5A5A5A5; clr_busy falls after the last word.
- **Collision:** clr_start in the same cycle as a writer transfer -> the writer word is stored and then overwritten by the clear. A second clr_start during CLEAR is ignored (single pass).
- **Reset mid-clear:** assert reset_P at clr_ptr=1000 -> clr_busy=0 the next cycle; words below 1000 = fill value, the rest unchanged.
